i2c_slave_regif: RTL and testbench

Synthesizable I2C slave that sits directly downstream of the testbench I2C master interface on the shared open-drain `scl`/`sda` nets. It recognises START/STOP, matches its 7-bit device address, and takes a register pointer byte followed by auto-incrementing data bytes. The result is converted into single-cycle write/read strobes on a simple register port that configures the filter datapath. It oversamples the bus with the system clock; it never drives `scl`, so clock stretching is not supported.

---
 rtl/i2c_slave_pkg.sv | 27 ++
 rtl/i2c_line_sync.sv | 31 +++
 rtl/i2c_slave_regif.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-port slave.
// Holds the FSM state encoding and bus-level constants.
package i2c_slave_pkg;

  localparam int BITCNT_W = 4;

  typedef logic [BITCNT_W-1:0] bitcnt_t;

  localparam bitcnt_t BYTE_BITS = 4'd8;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchroniser for one bus line with registered
// rise/fall detection; idles high like a released bus.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_slave_regif.sv
// Oversampling I2C slave: device address match, register pointer,
// auto-incrementing reads/writes on a single-cycle strobe port.
module i2c_slave_regif
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop, rx_state, byte_done;

  state_t     state_q, state_d;
  bitcnt_t    bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       busy_q, busy_d;
  logic       load_q;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i (scl_in),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i (sda_in),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start     = sda_fall & scl_lvl;
  assign stop      = sda_rise & scl_lvl;
  assign rx_state  = state_q inside {ADDR, PTR, WDATA};
  assign byte_done = scl_fall && (bitcnt_q == BYTE_BITS);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    we_d     = 1'b0;
    re_d     = 1'b0;

    // read data arrives the cycle after the strobe
    if (load_q) shreg_d = reg_rdata;

    if (start) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      busy_d   = 1'b1;
    end else if (stop) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
    end else begin
      if (rx_state && scl_rise && bitcnt_q < BYTE_BITS) begin
        shreg_d  = {shreg_q[6:0], sda_lvl};
        bitcnt_d = bitcnt_q + 1'b1;
      end

      unique case (state_q)
        ADDR: begin
          if (byte_done) begin
            bitcnt_d = '0;
            if (shreg_q[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              oe_d    = 1'b1;
              rw_d    = shreg_q[0];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise && rw_q == I2C_RW_READ) re_d = 1'b1;
          if (scl_fall) begin
            bitcnt_d = '0;
            if (rw_q == I2C_RW_READ) begin
              state_d = RDATA;
              oe_d    = ~shreg_q[7];
            end else begin
              state_d = PTR;
              oe_d    = 1'b0;
            end
          end
        end
        PTR: begin
          if (byte_done) begin
            bitcnt_d = '0;
            addr_d   = shreg_q;
            oe_d     = 1'b1;
            state_d  = PTR_ACK;
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = WDATA;
          end
        end
        WDATA: begin
          if (byte_done) begin
            bitcnt_d = '0;
            oe_d     = 1'b1;
            state_d  = WDATA_ACK;
          end
        end
        WDATA_ACK: begin
          if (scl_rise) begin
            we_d    = 1'b1;
            wdata_d = shreg_q;
          end
          if (scl_fall) begin
            oe_d    = 1'b0;
            addr_d  = addr_q + 8'd1;
            state_d = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = '0;
              oe_d     = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              oe_d = ~shreg_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              addr_d = addr_q + 8'd1;
              re_d   = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
          if (scl_fall) begin
            bitcnt_d = '0;
            oe_d     = ~shreg_q[7];
            state_d  = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      re_q     <= re_d;
      busy_q   <= busy_d;
      load_q   <= re_q;
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench: bit-banged I2C master, register-file model,
// strobe monitors and table-driven write transactions.
module tb_i2c_slave_regif;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int checks = 0;
  int fails  = 0;

  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic        oe_seen;
  int          width_err = 0;
  logic        we_p = 1'b0;
  logic        re_p = 1'b0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  always_comb begin
    reg_rdata = 8'hEE;
    if (reg_addr == 8'h20) reg_rdata = 8'hC3;
    if (reg_addr == 8'h21) reg_rdata = 8'h5A;
  end

  i2c_slave_regif #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (reg_we) wq.push_back({reg_addr, reg_wdata});
    if (reg_re) rq.push_back(reg_addr);
    if (sda_oe) oe_seen = 1'b1;
    if ((reg_we && we_p) || (reg_re && re_p)) width_err++;
    we_p = reg_we;
    re_p = reg_re;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wpop();
    if (wq.size() == 0) return 16'hDEAD;
    return wq.pop_front();
  endfunction

  function automatic logic [7:0] rpop();
    if (rq.size() == 0) return 8'hDD;
    return rq.pop_front();
  endfunction

  task automatic i2c_start();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
  endtask

  task automatic wbit(input logic b);
    sda_m = b;    #(Q);
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    b = sda_bus;  #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(nack);
  endtask

  typedef struct {
    string      name;
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] exp_ack;
    int         exp_n;
    logic [7:0] a0;
    logic [7:0] a1;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [3:0] ak;
    logic [2:0] rk;
    logic [7:0] d0, d1;
    logic       b;

    vt[0] = '{"write",  8'h84, 8'h10, 8'hA5, 8'h3C, 4'b0000, 2, 8'h10, 8'h11};
    vt[1] = '{"nomatch", 8'h86, 8'h10, 8'hA5, 8'h3C, 4'b1111, 0, 8'h00, 8'h00};
    vt[2] = '{"wrap",   8'h84, 8'hFF, 8'h11, 8'h22, 4'b0000, 2, 8'hFF, 8'h00};
    vt[3] = '{"write2", 8'h84, 8'h7E, 8'h00, 8'hFF, 4'b0000, 2, 8'h7E, 8'h7F};

    scl_m = 1'b1;
    sda_m = 1'b1;
    rst   = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset outs", {sda_oe, reg_we, reg_re, reg_addr, reg_wdata, busy}, '0);
    check("reset state", dut.state_q, i2c_slave_pkg::IDLE);
    rst = 1'b0;
    #(2*Q);

    for (int i = 0; i < 4; i++) begin
      wq.delete();
      oe_seen = 1'b0;
      i2c_start();
      send_byte(vt[i].dev, ak[3]);
      send_byte(vt[i].ptr, ak[2]);
      send_byte(vt[i].d0,  ak[1]);
      send_byte(vt[i].d1,  ak[0]);
      i2c_stop();
      #(2*Q);
      check($sformatf("%s acks", vt[i].name), ak, vt[i].exp_ack);
      check($sformatf("%s nwr", vt[i].name), wq.size(), vt[i].exp_n);
      if (vt[i].exp_n == 2) begin
        check($sformatf("%s wr0", vt[i].name), wpop(), {vt[i].a0, vt[i].d0});
        check($sformatf("%s wr1", vt[i].name), wpop(), {vt[i].a1, vt[i].d1});
      end
      check($sformatf("%s oe", vt[i].name), oe_seen, vt[i].exp_n != 0);
      check($sformatf("%s busy", vt[i].name), busy, 1'b0);
      check($sformatf("%s idle", vt[i].name), dut.state_q, i2c_slave_pkg::IDLE);
    end

    // read with repeated START; ACK first byte, NACK second
    wq.delete();
    rq.delete();
    i2c_start();
    check("rd busy", busy, 1'b1);
    send_byte(8'h84, rk[2]);
    send_byte(8'h20, rk[1]);
    i2c_start();
    send_byte(8'h85, rk[0]);
    recv_byte(d0, 1'b0);
    recv_byte(d1, 1'b1);
    check("rd acks", rk, 3'b000);
    check("rd byte0", d0, 8'hC3);
    check("rd byte1", d1, 8'h5A);
    check("rd release", sda_oe, 1'b0);
    i2c_stop();
    #(2*Q);
    check("rd nre", rq.size(), 2);
    check("rd re0", rpop(), 8'h20);
    check("rd re1", rpop(), 8'h21);
    check("rd nwr", wq.size(), 0);
    check("rd busy end", busy, 1'b0);

    // STOP after four data bits discards the partial byte
    wq.delete();
    i2c_start();
    send_byte(8'h84, ak[3]);
    send_byte(8'h30, ak[2]);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    i2c_stop();
    #(2*Q);
    check("abort nwr", wq.size(), 0);
    check("abort idle", dut.state_q, i2c_slave_pkg::IDLE);

    // reset while the slave is driving a 0 data bit
    rq.delete();
    i2c_start();
    send_byte(8'h84, rk[2]);
    send_byte(8'h20, rk[1]);
    i2c_start();
    send_byte(8'h85, rk[0]);
    rbit(b);
    rbit(b);
    check("rst pre oe", sda_oe, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst edge", {sda_oe, busy, reg_addr}, '0);
    @(negedge clk);
    rst = 1'b0;
    check("rst nre", rq.size(), 1);
    i2c_stop();
    #(2*Q);

    wq.delete();
    i2c_start();
    send_byte(8'h84, ak[2]);
    send_byte(8'h40, ak[1]);
    send_byte(8'h77, ak[0]);
    i2c_stop();
    #(2*Q);
    check("post acks", ak[2:0], 3'b000);
    check("post nwr", wq.size(), 1);
    check("post wr", wpop(), 16'h4077);
    check("strobe width", width_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
